uart_rx_frame_ctrl: RTL and testbench

Frame controller that sits downstream of the UART receiver. It consumes the received byte stream (Rx_Data/Rx_Done) and parses command frames of the form HDR, ADDR, LEN, DATA[LEN], CHK. Each payload is buffered and its checksum verified. A good frame is replayed as a burst of register writes over a valid/ready port with incrementing addresses. Malformed, corrupted or stalled frames are reported and discarded without issuing any writes.

---
 rtl/uart_rx_frame_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Command-frame parser behind a UART receiver: HDR, ADDR, LEN, DATA[LEN], CHK.
// Good frames are replayed as an incrementing-address write burst; bad or stalled frames are dropped.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] HDR_BYTE    = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] Rx_Data,
    input  logic       Rx_Done,
    output logic [7:0] Wr_Addr,
    output logic [7:0] Wr_Data,
    output logic       Wr_Valid,
    input  logic       Wr_Ready,
    output logic       Frame_Ok,
    output logic       Frame_Err,
    output logic [1:0] Err_Code,
    output logic       Rx_Ovr,
    output logic       Busy
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    LEN_MAX = 8'(MAX_LEN);

    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic [7:0]      r_base;
    logic [7:0]      r_len;
    logic [7:0]      r_wptr;
    logic [7:0]      r_rptr;
    logic [7:0]      r_csum;
    logic [TW-1:0]   r_tcnt;
    logic [7:0]      r_buf [MAX_LEN];

    logic [7:0]      r_wr_addr;
    logic [7:0]      r_wr_data;
    logic            r_wr_valid;
    logic            r_frame_ok;
    logic            r_frame_err;
    logic [1:0]      r_err_code;
    logic            r_rx_ovr;

    logic            w_in_frame;
    logic            w_tmo;
    logic            w_hs;
    logic            w_last_beat;
    logic [7:0]      w_csum_nxt;
    logic [7:0]      w_rnext;
    logic [AW-1:0]   w_widx;
    logic [AW-1:0]   w_ridx_nxt;

    assign w_in_frame  = (r_state == S_ADDR) || (r_state == S_LEN) ||
                         (r_state == S_DATA) || (r_state == S_CHK);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign w_tmo       = w_in_frame && !Rx_Done && (r_tcnt == TO_LAST);
    assign w_hs        = r_wr_valid && Wr_Ready;
    assign w_last_beat = (r_rptr == (r_len - 8'd1));
    assign w_csum_nxt  = r_csum + Rx_Data;
    assign w_rnext     = r_rptr + 8'd1;
    assign w_widx      = r_wptr[AW-1:0];
    assign w_ridx_nxt  = w_rnext[AW-1:0];

    // Payload storage is plain data: no reset, written only while collecting DATA bytes.
    always_ff @(posedge Clk) begin
        if (r_state == S_DATA && Rx_Done) begin
            r_buf[w_widx] <= Rx_Data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= 8'd0;
            r_len       <= 8'd0;
            r_wptr      <= 8'd0;
            r_rptr      <= 8'd0;
            r_csum      <= 8'd0;
            r_tcnt      <= '0;
            r_wr_addr   <= 8'd0;
            r_wr_data   <= 8'd0;
            r_wr_valid  <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= 2'd0;
            r_rx_ovr    <= 1'b0;
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_ovr    <= 1'b0;

            if (w_in_frame) begin
                r_tcnt <= Rx_Done ? '0 : r_tcnt + 1'b1;
            end else begin
                r_tcnt <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (Rx_Done && Rx_Data == HDR_BYTE) begin
                        r_csum  <= 8'd0;
                        r_state <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (Rx_Done) begin
                        r_base  <= Rx_Data;
                        r_csum  <= w_csum_nxt;
                        r_state <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (Rx_Done) begin
                        r_csum <= w_csum_nxt;
                        if (Rx_Data != 8'd0 && Rx_Data <= LEN_MAX) begin
                            r_len   <= Rx_Data;
                            r_wptr  <= 8'd0;
                            r_state <= S_DATA;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_LEN;
                            r_state     <= S_IDLE;
                        end
                    end
                end

                S_DATA: begin
                    if (Rx_Done) begin
                        r_csum <= w_csum_nxt;
                        r_wptr <= r_wptr + 8'd1;
                        if ((r_wptr + 8'd1) == r_len) begin
                            r_state <= S_CHK;
                        end
                    end
                end

                S_CHK: begin
                    if (Rx_Done) begin
                        if (Rx_Data == r_csum) begin
                            r_rptr     <= 8'd0;
                            r_wr_valid <= 1'b1;
                            r_wr_addr  <= r_base;
                            r_wr_data  <= r_buf[0];
                            r_state    <= S_DRAIN;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_CHK;
                            r_state     <= S_IDLE;
                        end
                    end
                end

                S_DRAIN: begin
                    // Bytes cannot be parsed while the burst is being replayed.
                    if (Rx_Done) begin
                        r_rx_ovr <= 1'b1;
                    end
                    if (w_hs) begin
                        if (w_last_beat) begin
                            r_wr_valid <= 1'b0;
                            r_frame_ok <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_rptr    <= w_rnext;
                            r_wr_addr <= r_base + w_rnext;
                            r_wr_data <= r_buf[w_ridx_nxt];
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_tmo) begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_TMO;
                r_tcnt      <= '0;
                r_state     <= S_IDLE;
            end
        end
    end

    assign Wr_Addr   = r_wr_addr;
    assign Wr_Data   = r_wr_data;
    assign Wr_Valid  = r_wr_valid;
    assign Frame_Ok  = r_frame_ok;
    assign Frame_Err = r_frame_err;
    assign Err_Code  = r_err_code;
    assign Rx_Ovr    = r_rx_ovr;
    assign Busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: frames are driven byte by byte, expected writes are queued
// at send time and popped by a handshake monitor.
module tb_uart_rx_frame_ctrl;

    localparam int         MAX_LEN = 16;
    localparam int         TO      = 100;
    localparam logic [7:0] HDR     = 8'hA5;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [7:0] Rx_Data = 8'd0;
    logic       Rx_Done = 1'b0;
    logic       Wr_Ready = 1'b1;
    logic [7:0] Wr_Addr;
    logic [7:0] Wr_Data;
    logic       Wr_Valid;
    logic       Frame_Ok;
    logic       Frame_Err;
    logic [1:0] Err_Code;
    logic       Rx_Ovr;
    logic       Busy;

    uart_rx_frame_ctrl #(
        .HDR_BYTE    (HDR),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TO)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Rx_Data   (Rx_Data),
        .Rx_Done   (Rx_Done),
        .Wr_Addr   (Wr_Addr),
        .Wr_Data   (Wr_Data),
        .Wr_Valid  (Wr_Valid),
        .Wr_Ready  (Wr_Ready),
        .Frame_Ok  (Frame_Ok),
        .Frame_Err (Frame_Err),
        .Err_Code  (Err_Code),
        .Rx_Ovr    (Rx_Ovr),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  pay[$];

    int         ok_cnt = 0, err_cnt = 0, ovr_cnt = 0, wr_cnt = 0;
    int         ok_cyc = 0, err_cyc = 0, last_wr_cyc = 0, prev_wr_cyc = 0;
    logic [1:0] last_code = 2'd0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_addr = 8'd0, stall_data = 8'd0;

    // Handshake monitor: sampled on the falling edge, away from the active edge.
    always @(negedge Clk) begin
        logic [15:0] e;
        if (!Rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (Wr_Valid && stall_prev) begin
                checks++;
                if ({Wr_Addr, Wr_Data} !== {stall_addr, stall_data}) begin
                    failures++;
                    $display("FAIL hold_stable: got %h/%h required %h/%h", Wr_Addr, Wr_Data, stall_addr, stall_data);
                end
            end
            stall_prev = Wr_Valid && !Wr_Ready;
            stall_addr = Wr_Addr;
            stall_data = Wr_Data;
            if (Wr_Valid && Wr_Ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: got %h/%h required no write", Wr_Addr, Wr_Data);
                end else begin
                    e = exp_q.pop_front();
                    if ({Wr_Addr, Wr_Data} !== e) begin
                        failures++;
                        $display("FAIL write_value: got %h/%h required %h/%h", Wr_Addr, Wr_Data, e[15:8], e[7:0]);
                    end
                end
                prev_wr_cyc = last_wr_cyc;
                last_wr_cyc = cyc;
                wr_cnt++;
            end
            if (Frame_Ok || Frame_Err) begin
                checks++;
                if (Frame_Ok && Frame_Err) begin
                    failures++;
                    $display("FAIL ok_err_exclusive: got ok=1 err=1 required not both");
                end
            end
            if (Frame_Ok) begin ok_cnt++; ok_cyc = cyc; end
            if (Frame_Err) begin err_cnt++; err_cyc = cyc; last_code = Err_Code; end
            if (Rx_Ovr) ovr_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        Rx_Data = b;
        Rx_Done = 1'b1;
        tick(1);
        Rx_Done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input bit corrupt);
        logic [7:0] sum;
        sum = base + 8'(pay.size());
        send_byte(HDR);
        send_byte(base);
        send_byte(8'(pay.size()));
        foreach (pay[i]) begin
            send_byte(pay[i]);
            sum = sum + pay[i];
            if (!corrupt) exp_q.push_back({8'(base + 8'(i)), pay[i]});
        end
        send_byte(corrupt ? sum - 8'd1 : sum);
    endtask

    task automatic test_reset;
        Rst_n = 1'b0;
        tick(3);
        checks++;
        if ({Wr_Addr, Wr_Data, Wr_Valid, Frame_Ok, Frame_Err, Err_Code, Rx_Ovr, Busy} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h %h %b %b %b %0d %b %b required all zero",
                     Wr_Addr, Wr_Data, Wr_Valid, Frame_Ok, Frame_Err, Err_Code, Rx_Ovr, Busy);
        end
        Rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_good_frame;
        int ok0, err0;
        ok0 = ok_cnt; err0 = err_cnt;
        pay = '{8'h33, 8'h44};
        send_frame(8'h10, 1'b0);
        checks++;
        if (Wr_Valid !== 1'b1) begin
            failures++;
            $display("FAIL good_valid_latency: got %b required 1", Wr_Valid);
        end
        for (int i = 0; i < 50 && ok_cnt == ok0; i++) tick(1);
        checks++;
        if (ok_cnt !== ok0 + 1) begin
            failures++;
            $display("FAIL good_frame_ok: got %0d pulses required 1", ok_cnt - ok0);
        end
        checks++;
        if (last_wr_cyc - prev_wr_cyc !== 1) begin
            failures++;
            $display("FAIL good_back_to_back: got gap %0d required 1", last_wr_cyc - prev_wr_cyc);
        end
        checks++;
        if (ok_cyc - last_wr_cyc !== 1) begin
            failures++;
            $display("FAIL good_ok_latency: got %0d required 1", ok_cyc - last_wr_cyc);
        end
        checks++;
        if (err_cnt !== err0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL good_no_err: got err=%0d pending=%0d required 0/0", err_cnt - err0, exp_q.size());
        end
    endtask

    task automatic test_wrap_backpressure;
        int ok0, wr0;
        ok0 = ok_cnt;
        Wr_Ready = 1'b0;
        pay = '{8'h01, 8'h02};
        send_frame(8'hFF, 1'b0);
        wr0 = wr_cnt;
        checks++;
        if ({Wr_Valid, Wr_Addr, Wr_Data} !== {1'b1, 8'hFF, 8'h01}) begin
            failures++;
            $display("FAIL wrap_first_word: got %b %h/%h required 1 ff/01", Wr_Valid, Wr_Addr, Wr_Data);
        end
        tick(5);
        checks++;
        if (wr_cnt !== wr0 || Wr_Valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_stalled: got writes=%0d valid=%b required 0/1", wr_cnt - wr0, Wr_Valid);
        end
        Wr_Ready = 1'b1;
        for (int i = 0; i < 50 && ok_cnt == ok0; i++) tick(1);
        checks++;
        if (ok_cnt !== ok0 + 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_complete: got ok=%0d pending=%0d required 1/0", ok_cnt - ok0, exp_q.size());
        end
    endtask

    task automatic test_bad_checksum;
        int wr0;
        wr0 = wr_cnt;
        pay = '{8'h33, 8'h44};
        send_frame(8'h10, 1'b1);
        checks++;
        if ({Frame_Err, Err_Code, Wr_Valid} !== {1'b1, 2'd2, 1'b0}) begin
            failures++;
            $display("FAIL bad_chk: got err=%b code=%0d valid=%b required 1/2/0", Frame_Err, Err_Code, Wr_Valid);
        end
        tick(10);
        checks++;
        if (wr_cnt !== wr0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_chk_discard: got writes=%0d busy=%b required 0/0", wr_cnt - wr0, Busy);
        end
    endtask

    task automatic test_bad_length;
        logic [7:0] lens [2];
        lens[0] = 8'h00;
        lens[1] = 8'h11;
        for (int k = 0; k < 2; k++) begin
            send_byte(HDR);
            send_byte(8'h10);
            send_byte(lens[k]);
            checks++;
            if ({Frame_Err, Err_Code, Busy} !== {1'b1, 2'd1, 1'b0}) begin
                failures++;
                $display("FAIL bad_len_%h: got err=%b code=%0d busy=%b required 1/1/0", lens[k], Frame_Err, Err_Code, Busy);
            end
            tick(2);
        end
    endtask

    task automatic test_timeout;
        int err0, ok0, t0;
        err0 = err_cnt;
        send_byte(HDR);
        send_byte(8'h10);
        t0 = cyc;
        for (int i = 0; i < 2 * TO && err_cnt == err0; i++) tick(1);
        checks++;
        if (err_cnt !== err0 + 1 || last_code !== 2'd3) begin
            failures++;
            $display("FAIL timeout_err: got pulses=%0d code=%0d required 1/3", err_cnt - err0, last_code);
        end
        checks++;
        if (err_cyc - t0 !== TO) begin
            failures++;
            $display("FAIL timeout_latency: got %0d required %0d", err_cyc - t0, TO);
        end
        ok0 = ok_cnt;
        pay = '{8'h55};
        send_frame(8'h30, 1'b0);
        for (int i = 0; i < 50 && ok_cnt == ok0; i++) tick(1);
        checks++;
        if (ok_cnt !== ok0 + 1) begin
            failures++;
            $display("FAIL timeout_recover: got ok=%0d required 1", ok_cnt - ok0);
        end
        // Byte lands exactly in the expiry cycle.
        err0 = err_cnt;
        ok0 = ok_cnt;
        send_byte(HDR);
        send_byte(8'h10);
        tick(TO - 1);
        send_byte(8'h02);
        exp_q.push_back({8'h10, 8'h33});
        exp_q.push_back({8'h11, 8'h44});
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h89);
        for (int i = 0; i < 50 && ok_cnt == ok0; i++) tick(1);
        checks++;
        if (err_cnt !== err0 || ok_cnt !== ok0 + 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_byte_wins: got err=%0d ok=%0d pending=%0d required 0/1/0",
                     err_cnt - err0, ok_cnt - ok0, exp_q.size());
        end
    endtask

    task automatic test_overrun;
        int ok0, ovr0;
        ok0 = ok_cnt;
        ovr0 = ovr_cnt;
        Wr_Ready = 1'b0;
        pay = '{8'h77};
        send_frame(8'h20, 1'b0);
        tick(1);
        send_byte(HDR);
        checks++;
        if (Rx_Ovr !== 1'b1 || Wr_Valid !== 1'b1) begin
            failures++;
            $display("FAIL overrun_pulse: got ovr=%b valid=%b required 1/1", Rx_Ovr, Wr_Valid);
        end
        tick(2);
        Wr_Ready = 1'b1;
        for (int i = 0; i < 50 && ok_cnt == ok0; i++) tick(1);
        checks++;
        if (ok_cnt !== ok0 + 1 || ovr_cnt !== ovr0 + 1 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL overrun_complete: got ok=%0d ovr=%0d busy=%b required 1/1/0", ok_cnt - ok0, ovr_cnt - ovr0, Busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        int ok0, err0;
        send_byte(HDR);
        send_byte(8'h10);
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        Rst_n = 1'b0;
        tick(1);
        checks++;
        if ({Wr_Addr, Wr_Data, Wr_Valid, Frame_Ok, Frame_Err, Err_Code, Rx_Ovr, Busy} !== 23'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got %h %h %b %b %b %0d %b %b required all zero",
                     Wr_Addr, Wr_Data, Wr_Valid, Frame_Ok, Frame_Err, Err_Code, Rx_Ovr, Busy);
        end
        tick(1);
        Rst_n = 1'b1;
        tick(1);
        ok0 = ok_cnt;
        err0 = err_cnt;
        pay = '{8'hC3, 8'h3C, 8'h5A};
        send_frame(8'h80, 1'b0);
        for (int i = 0; i < 50 && ok_cnt == ok0; i++) tick(1);
        checks++;
        if (ok_cnt !== ok0 + 1 || err_cnt !== err0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_next_frame: got ok=%0d err=%0d pending=%0d required 1/0/0",
                     ok_cnt - ok0, err_cnt - err0, exp_q.size());
        end
    endtask

    task automatic test_junk;
        int ok0;
        send_byte(8'h00);
        send_byte(8'hFF);
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("FAIL junk_idle: got busy=%b required 0", Busy);
        end
        ok0 = ok_cnt;
        pay = '{8'hDE, 8'hAD};
        send_frame(8'h40, 1'b0);
        for (int i = 0; i < 50 && ok_cnt == ok0; i++) tick(1);
        checks++;
        if (ok_cnt !== ok0 + 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL junk_frame: got ok=%0d pending=%0d required 1/0", ok_cnt - ok0, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        int ok0, wr0;
        ok0 = ok_cnt;
        wr0 = wr_cnt;
        pay = {};
        for (int i = 0; i < MAX_LEN; i++) pay.push_back(8'(i * 7 + 3));
        send_frame(8'hF8, 1'b0);
        for (int i = 0; i < 100 && ok_cnt == ok0; i++) tick(1);
        checks++;
        if (ok_cnt !== ok0 + 1 || wr_cnt - wr0 !== MAX_LEN || exp_q.size() != 0) begin
            failures++;
            $display("FAIL maxlen_burst: got ok=%0d writes=%0d pending=%0d required 1/%0d/0",
                     ok_cnt - ok0, wr_cnt - wr0, exp_q.size(), MAX_LEN);
        end
        checks++;
        if (ok_cyc - last_wr_cyc !== 1) begin
            failures++;
            $display("FAIL maxlen_ok_latency: got %0d required 1", ok_cyc - last_wr_cyc);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_good_frame();
        test_wrap_backpressure();
        test_bad_checksum();
        test_bad_length();
        test_timeout();
        test_overrun();
        test_reset_mid_frame();
        test_junk();
        test_back_to_back();
        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_pending: got %0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
